transmitter_rs_232: RTL



---
 rtl/uart_pkg.sv | 23 ++
 rtl/transmitter_baud_tick.sv | 31 +++
 rtl/transmitter_rs_232.sv | 124 ++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter FSM states, default frame constants,
// and a frame-length helper.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

  localparam int UART_BAUD_COUNT = 434;
  localparam int UART_DATA_WIDTH = 8;

  function automatic int frame_bits(
    input int data_width,
    input bit parity
  );
    return data_width + (parity ? 3 : 2);
  endfunction

endpackage

// File: rtl/transmitter_baud_tick.sv
// Bit-time counter: counts 0..BAUD_COUNT-1, tick marks the last cycle.
// Ports: clock, reset_n, clear (sync), tick.
module transmitter_baud_tick #(
  parameter int BAUD_COUNT = 434
) (
  input  logic clock,
  input  logic reset_n,
  input  logic clear,
  output logic tick
);

  localparam int CW =
    (BAUD_COUNT > 1) ? $clog2(BAUD_COUNT) : 1;
  localparam logic [CW-1:0] LAST =
    CW'(BAUD_COUNT - 1);

  logic [CW-1:0] baud_counter;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      baud_counter <= '0;
    end else if (clear) begin
      baud_counter <= '0;
    end else begin
      baud_counter <= baud_counter + CW'(1);
    end
  end

  assign tick = (baud_counter == LAST);

endmodule

// File: rtl/transmitter_rs_232.sv
// RS-232 transmitter: start, DATA_WIDTH bits LSB first, [parity], stop.
// Ports: clock, reset_n, transmit_valid/data/ready, serial_data_out,
// transmitting_flag. Even parity bit enabled by TRANSMITTER_PARITY_EN.
module transmitter_rs_232
  import uart_pkg::*;
#(
  parameter int BAUD_COUNT = UART_BAUD_COUNT,
  parameter int DATA_WIDTH = UART_DATA_WIDTH
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  transmit_valid,
  input  logic [DATA_WIDTH-1:0] transmit_data,
  output logic                  transmit_ready,
  output logic                  serial_data_out,
  output logic                  transmitting_flag
);

  localparam int BW =
    (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [BW-1:0] LAST_BIT =
    BW'(DATA_WIDTH - 1);

  tx_state_t             state;
  logic [DATA_WIDTH-1:0] shift_register;
  logic [DATA_WIDTH-1:0] shift_next;
  logic [BW-1:0]         bit_counter;
  logic                  tick;
  logic                  clear;
  logic                  accept;
`ifdef TRANSMITTER_PARITY_EN
  logic                  parity_bit;
`endif

  assign accept     = transmit_valid && transmit_ready;
  assign shift_next = shift_register >> 1;
  // Held at zero while idle, restarted at every bit boundary.
  assign clear      = (state == IDLE) || tick;

  transmitter_baud_tick #(
    .BAUD_COUNT(BAUD_COUNT)
  ) u_baud (
    .clock  (clock),
    .reset_n(reset_n),
    .clear  (clear),
    .tick   (tick)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state             <= IDLE;
      serial_data_out   <= 1'b1;
      transmit_ready    <= 1'b1;
      transmitting_flag <= 1'b0;
      shift_register    <= '0;
      bit_counter       <= '0;
`ifdef TRANSMITTER_PARITY_EN
      parity_bit        <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            state             <= START;
            shift_register    <= transmit_data;
            bit_counter       <= '0;
            serial_data_out   <= 1'b0;
            transmit_ready    <= 1'b0;
            transmitting_flag <= 1'b1;
`ifdef TRANSMITTER_PARITY_EN
            parity_bit        <= ^transmit_data;
`endif
          end
        end
        START: begin
          if (tick) begin
            state           <= DATA;
            serial_data_out <= shift_register[0];
          end
        end
        DATA: begin
          if (tick) begin
            if (bit_counter == LAST_BIT) begin
`ifdef TRANSMITTER_PARITY_EN
              state           <= PARITY;
              serial_data_out <= parity_bit;
`else
              state           <= STOP;
              serial_data_out <= 1'b1;
`endif
            end else begin
              bit_counter     <= bit_counter + BW'(1);
              shift_register  <= shift_next;
              serial_data_out <= shift_next[0];
            end
          end
        end
`ifdef TRANSMITTER_PARITY_EN
        PARITY: begin
          if (tick) begin
            state           <= STOP;
            serial_data_out <= 1'b1;
          end
        end
`endif
        STOP: begin
          if (tick) begin
            state             <= IDLE;
            serial_data_out   <= 1'b1;
            transmit_ready    <= 1'b1;
            transmitting_flag <= 1'b0;
          end
        end
        default: begin
          state             <= IDLE;
          serial_data_out   <= 1'b1;
          transmit_ready    <= 1'b1;
          transmitting_flag <= 1'b0;
        end
      endcase
    end
  end

endmodule
